fp_round_arb: RTL and testbench

- Shares one pipelined rounding unit (fpRound-style, LAT-stage, clock-enabled) among NREQ requesters.
- Picks one requester round-robin per advancing cycle and resolves the dynamic rounding mode against the global frm.
- Drives the rounder's i/rm/ce, carries a tag and flags alongside it, and returns each result with its tag through a valid/ready port.
- Sits between the FPU op units (add/mul/div/cvt) and the shared rounding stage.

---
 rtl/fp_round_arb.sv | 129 ++++++++++++
 tb/tb_fp_round_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_arb.sv
// fp_round_arb: round-robin arbiter in front of one shared, clock-enabled,
// LAT-stage rounding unit. A shadow pipeline carries {vld, tag, illegal}
// next to the rounder, so each rounded result comes back with the index of
// the requester that issued it.
module fp_round_arb #(
    parameter int FPWID = 64,
    parameter int NREQ  = 4,
    parameter int TAGW  = 2,
    parameter int LAT   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*(FPWID+4)-1:0]  req_i,
    input  logic [NREQ*3-1:0]          req_rm,
    input  logic [2:0]                 frm,
    output logic                       rnd_ce,
    output logic [FPWID+3:0]           rnd_i,
    output logic [2:0]                 rnd_rm,
    input  logic [FPWID-1:0]           rnd_o,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [FPWID-1:0]           res_o,
    output logic [TAGW-1:0]            res_tag,
    output logic                       res_illegal,
    output logic                       busy
);

    localparam int IW = FPWID + 4;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Returns {illegal, rm_to_rounder}. Mode 7 takes the global frm; modes
    // 5..7 after resolution are reserved and fall back to truncation.
    function automatic logic [3:0] resolve_rm(input logic [2:0] rm,
                                              input logic [2:0] dyn);
        logic [2:0] eff;
        eff = (rm == 3'd7) ? dyn : rm;
        if (eff >= 3'd5)
            return {1'b1, 3'd1};
        else
            return {1'b0, eff};
    endfunction

    // Last granted requester; the search starts one past it.
    logic [PW-1:0]   ptr;

    // Shadow pipeline, lock-stepped with the rounder through rnd_ce.
    logic [LAT-1:0]  slot_vld;
    logic [LAT-1:0]  slot_ill;
    logic [TAGW-1:0] slot_tag [LAT];

    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic            issue;
    logic [IW-1:0]   sel_i;
    logic [2:0]      sel_rm;
    logic [3:0]      rm_res;

    assign res_valid   = slot_vld[LAT-1];
    assign res_tag     = slot_tag[LAT-1];
    assign res_illegal = slot_ill[LAT-1];
    assign res_o       = rnd_o;
    assign busy        = |slot_vld;

    // The rounder advances whenever the output slot is empty or drained;
    // during reset it keeps running so its contents flush out as bubbles.
    assign rnd_ce = rst | ~res_valid | res_ready;
    assign issue  = grant_any & rnd_ce & ~rst;

    // Round-robin search from ptr+1 upward, wrapping modulo NREQ.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_w;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_w     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx   = (int'(ptr) + off) % NREQ;
            idx_w = PW'(idx);
            if (!grant_any && req_valid[idx_w]) begin
                grant_any = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    // One-hot ready plus operand / mode mux for the selected requester.
    always_comb begin
        req_ready = '0;
        sel_i     = req_i[IW-1:0];
        sel_rm    = req_rm[2:0];
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == PW'(k)) begin
                sel_i  = req_i[k*IW +: IW];
                sel_rm = req_rm[k*3 +: 3];
                req_ready[k] = issue;
            end
        end
    end

    assign rm_res = resolve_rm(sel_rm, frm);
    assign rnd_i  = sel_i;
    assign rnd_rm = rm_res[2:0];

    // Shadow pipeline and round-robin pointer; frozen whenever rnd_ce is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
            slot_ill <= '0;
            for (int s = 0; s < LAT; s++)
                slot_tag[s] <= '0;
            ptr <= PW'(NREQ - 1);
        end else if (rnd_ce) begin
            slot_vld[0] <= issue;
            slot_ill[0] <= issue & rm_res[3];
            slot_tag[0] <= issue ? TAGW'(grant_idx) : '0;
            for (int s = 1; s < LAT; s++) begin
                slot_vld[s] <= slot_vld[s-1];
                slot_ill[s] <= slot_ill[s-1];
                slot_tag[s] <= slot_tag[s-1];
            end
            if (issue)
                ptr <= grant_idx;
        end
    end

endmodule

// File: tb/tb_fp_round_arb.sv
// Directed bench for fp_round_arb with a behavioural LAT-stage rounder model.
module tb_fp_round_arb;

    localparam int FPWID = 64;
    localparam int NREQ  = 4;
    localparam int TAGW  = 2;
    localparam int LAT   = 3;
    localparam int IW    = FPWID + 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*IW-1:0]    req_i;
    logic [NREQ*3-1:0]     req_rm;
    logic [2:0]            frm;
    logic                  rnd_ce;
    logic [IW-1:0]         rnd_i;
    logic [2:0]            rnd_rm;
    logic [FPWID-1:0]      rnd_o;
    logic                  res_valid;
    logic                  res_ready;
    logic [FPWID-1:0]      res_o;
    logic [TAGW-1:0]       res_tag;
    logic                  res_illegal;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    fp_round_arb #(.FPWID(FPWID), .NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_i(req_i), .req_rm(req_rm), .frm(frm),
        .rnd_ce(rnd_ce), .rnd_i(rnd_i), .rnd_rm(rnd_rm), .rnd_o(rnd_o),
        .res_valid(res_valid), .res_ready(res_ready), .res_o(res_o),
        .res_tag(res_tag), .res_illegal(res_illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rounding of the intermediate format.
    function automatic logic [63:0] round_model(input logic [67:0] x, input logic [2:0] rm);
        logic        sgn, g, r, s, lsb, inc;
        logic [62:0] mag;
        sgn = x[67];
        mag = {x[66:56], x[54:3]};
        lsb = x[3];
        g = x[2]; r = x[1]; s = x[0];
        case (rm)
            3'd0: inc = g & (r | s | lsb);
            3'd2: inc = sgn & (g | r | s);
            3'd3: inc = ~sgn & (g | r | s);
            3'd4: inc = g;
            default: inc = 1'b0;
        endcase
        return {sgn, mag + 63'(inc)};
    endfunction

    // Rounder model: LAT stages, all gated by rnd_ce.
    logic [63:0] rpipe [LAT];
    always_ff @(posedge clk) begin
        if (rnd_ce) begin
            rpipe[0] <= round_model(rnd_i, rnd_rm);
            for (int s = 1; s < LAT; s++)
                rpipe[s] <= rpipe[s-1];
        end
    end
    assign rnd_o = rpipe[LAT-1];

    function automatic logic [67:0] mk_i(input int frac);
        return {1'b0, 11'h3FF, 1'b1, 52'(frac), 3'b000};
    endfunction

    function automatic logic [63:0] mk_o(input int frac);
        return {1'b0, 11'h3FF, 52'(frac)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One request from requester k with everything else idle; result is
    // expected exactly LAT cycles after the grant.
    task automatic single_op(input string name, input int k, input logic [67:0] i,
                             input logic [2:0] rm, input logic [2:0] f,
                             input logic [63:0] exp_o, input logic exp_ill,
                             input logic [2:0] exp_rm);
        frm = f;
        req_i[k*IW +: IW] = i;
        req_rm[k*3 +: 3] = rm;
        req_valid = 4'(1 << k);
        #1;
        check({name, ".ready"}, 64'(req_ready), 64'(1 << k));
        check({name, ".rnd_rm"}, 64'(rnd_rm), 64'(exp_rm));
        tick();
        req_valid = '0;
        #1;
        check({name, ".rv1"}, 64'(res_valid), 64'd0);
        tick();
        #1;
        check({name, ".rv2"}, 64'(res_valid), 64'd0);
        tick();
        #1;
        check({name, ".rv3"}, 64'(res_valid), 64'd1);
        check({name, ".res_o"}, res_o, exp_o);
        check({name, ".tag"}, 64'(res_tag), 64'(k));
        check({name, ".ill"}, 64'(res_illegal), 64'(exp_ill));
        tick();
        #1;
        check({name, ".rv4"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        int issued;
        logic exp_grant;
        logic exp_rv;
        int ridx;

        rst = 1'b1;
        req_valid = '0;
        req_i = '0;
        req_rm = '0;
        frm = 3'd0;
        res_ready = 1'b1;

        // Reset state
        do_reset();
        #1;
        check("rst.res_valid", 64'(res_valid), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.req_ready", 64'(req_ready), 64'd0);
        check("rst.res_tag", 64'(res_tag), 64'd0);
        check("rst.res_ill", 64'(res_illegal), 64'd0);
        check("rst.rnd_ce", 64'(rnd_ce), 64'd1);
        tick();

        // Single ops and rounding-mode resolution
        single_op("rne", 0, 68'h3FF80000000000004, 3'd0, 3'd0, 64'h3FF0000000000000, 1'b0, 3'd0);
        single_op("rmm", 0, 68'h3FF80000000000004, 3'd4, 3'd0, 64'h3FF0000000000001, 1'b0, 3'd4);
        single_op("dyn4", 0, 68'h3FF80000000000004, 3'd7, 3'd4, 64'h3FF0000000000001, 1'b0, 3'd4);
        single_op("dyn6", 0, 68'h3FF80000000000004, 3'd7, 3'd6, 64'h3FF0000000000000, 1'b1, 3'd1);
        single_op("rm5", 2, 68'h3FF80000000000004, 3'd5, 3'd0, 64'h3FF0000000000000, 1'b1, 3'd1);
        single_op("rup", 3, 68'h3FF80000000000001, 3'd3, 3'd0, 64'h3FF0000000000001, 1'b0, 3'd3);

        // Fairness: all requesters active for 8 cycles after reset
        do_reset();
        frm = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            req_i[k*IW +: IW] = mk_i(k + 1);
            req_rm[k*3 +: 3] = 3'd0;
        end
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            check($sformatf("fair.ready%0d", c), 64'(req_ready), (c < 8) ? 64'(1 << (c % 4)) : 64'd0);
            check($sformatf("fair.rv%0d", c), 64'(res_valid), (c >= 3 && c < 11) ? 64'd1 : 64'd0);
            if (c >= 3) begin
                check($sformatf("fair.tag%0d", c), 64'(res_tag), 64'((c - 3) % 4));
                check($sformatf("fair.res%0d", c), res_o, mk_o(((c - 3) % 4) + 1));
            end
            tick();
        end
        #1;
        check("fair.drained", 64'(busy), 64'd0);
        tick();

        // Backpressure: 5 ops from requester 0, res_ready low for 4 cycles
        do_reset();
        issued = 0;
        for (int c = 0; c < 13; c++) begin
            exp_grant = (c < 3) || (c == 7) || (c == 8);
            exp_rv = (c >= 3) && (c <= 11);
            ridx = (c <= 7) ? 0 : c - 7;
            res_ready = !(c >= 3 && c <= 6);
            req_valid = (issued < 5) ? 4'b0001 : 4'b0000;
            req_i[0 +: IW] = mk_i(16 + issued);
            req_rm[2:0] = 3'd0;
            #1;
            check($sformatf("bp.ready%0d", c), 64'(req_ready), exp_grant ? 64'd1 : 64'd0);
            check($sformatf("bp.ce%0d", c), 64'(rnd_ce), (c >= 3 && c <= 6) ? 64'd0 : 64'd1);
            check($sformatf("bp.rv%0d", c), 64'(res_valid), 64'(exp_rv));
            if (exp_rv)
                check($sformatf("bp.res%0d", c), res_o, mk_o(16 + ridx));
            if (exp_grant)
                issued++;
            tick();
        end
        res_ready = 1'b1;

        // Reset mid-flight: ptr is 0 here, so requesters 1,2,0 are granted
        for (int k = 0; k < NREQ; k++)
            req_i[k*IW +: IW] = mk_i(32 + k);
        req_valid = 4'b0111;
        #1;
        check("mf.g1", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b0101;
        #1;
        check("mf.g2", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0001;
        #1;
        check("mf.g0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0000;
        rst = 1'b1;
        #1;
        check("mf.rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0011;
        #1;
        check("mf.post_rv", 64'(res_valid), 64'd0);
        check("mf.post_busy", 64'(busy), 64'd0);
        check("mf.ptr_reset", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0010;
        #1;
        check("mf.req1_ready", 64'(req_ready), 64'b0010);
        check("mf.stale1", 64'(res_valid), 64'd0);
        tick();
        req_valid = 4'b0000;
        #1;
        check("mf.stale2", 64'(res_valid), 64'd0);
        tick();
        #1;
        check("mf.r0_rv", 64'(res_valid), 64'd1);
        check("mf.r0_tag", 64'(res_tag), 64'd0);
        check("mf.r0_res", res_o, mk_o(32));
        tick();
        #1;
        check("mf.r1_rv", 64'(res_valid), 64'd1);
        check("mf.r1_tag", 64'(res_tag), 64'd1);
        check("mf.r1_res", res_o, mk_o(33));
        tick();
        #1;
        check("mf.end_rv", 64'(res_valid), 64'd0);
        check("mf.end_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
